multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multicycle datapath controller; next generation of the two-state fetch/decode sequencer.
- Decodes opcode/funct into a full FSM covering R-type, addi, lw, sw, beq, bne and j.
- Adds a memory-ready handshake, branch-condition gating and an illegal-opcode trap.
- Sits between the instruction register and the datapath muxes, register file, ALU and memories.

Parameters:
- OPCODE_W, 6: opcode field width.
- ALUOP_W, 3: ALUOp output width.
- STATE_W, 4: state register width, exported on state_out.
- TIMEOUT_CYCLES, 255: maximum consecutive memory-wait cycles. Used only with CTRL_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  instruction opcode from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcWrite  out  1  PC load enable
- pcSource  out  2  00 = ALU result, 01 = AluOut, 10 = jump target
- MuxAlu1Sel  out  1  ALU A select: 0 = PC, 1 = regA
- Mux4Sel  out  2  ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- ALUOp  out  ALUOP_W  1 = ADD, 2 = SUB, 7 = decode funct
- IMemRead, DMemRead, wrMem  out  1 each  memory strobes
- Load_ir, LoadMDR  out  1 each  instruction register / MDR load
- regAWrite, regBWrite, AluOutWrite  out  1 each  datapath register loads
- regWrite, regDst, memtoReg  out  1 each  register-file write controls
- trap  out  1  controller halted
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout
- state_out  out  STATE_W  current state, for debug

Behaviour:
- Single clock (clk). Reset is synchronous and active-high on reset, sampled on the rising edge.
- Reset:
  - Forces state RST(0). In RST all outputs are 0 and trap_cause = 00.
  - RST advances to FETCH on the next cycle.
  - Reset asserted in any state, including mid memory wait or TRAP, returns to RST on the next edge.
- Unlisted outputs are 0 in every state. Outputs decode combinationally from state, plus mem_ready and zero where stated.
- FETCH(1):
  - IMemRead = 1, MuxAlu1Sel = 0, Mux4Sel = 01, ALUOp = ADD.
  - If mem_ready: Load_ir = 1, pcWrite = 1, pcSource = 00, next DECODE.
  - Otherwise hold FETCH with pcWrite and Load_ir at 0.
- DECODE(2):
  - regAWrite = regBWrite = 1, Mux4Sel = 11, ALUOp = ADD, AluOutWrite = 1.
  - Next state by opcode: 0x00 → EXEC_R; 0x23 or 0x2B → ADDR; 0x04 or 0x05 → BRANCH; 0x02 → JUMP; 0x08 → ADDI_EX.
  - Any other opcode → TRAP with trap_cause = 01.
- EXEC_R(3): MuxAlu1Sel = 1, Mux4Sel = 00, ALUOp = 7, AluOutWrite = 1. Next R_WB.
- R_WB(4): regWrite = 1, regDst = 1, memtoReg = 0. Next FETCH.
- ADDR(5): MuxAlu1Sel = 1, Mux4Sel = 10, ALUOp = ADD, AluOutWrite = 1. Next MEM_RD if opcode = 0x23, else MEM_WR.
- MEM_RD(6): DMemRead = 1. If mem_ready: LoadMDR = 1, next LD_WB; otherwise hold.
- LD_WB(7): regWrite = 1, regDst = 0, memtoReg = 1. Next FETCH.
- MEM_WR(8): wrMem = 1, held until mem_ready. Then next FETCH.
- BRANCH(9):
  - MuxAlu1Sel = 1, Mux4Sel = 00, ALUOp = SUB, pcSource = 01.
  - pcWrite = zero for opcode 0x04, pcWrite = !zero for opcode 0x05.
  - Next FETCH.
- JUMP(10): pcSource = 10, pcWrite = 1. Next FETCH.
- ADDI_EX(11): MuxAlu1Sel = 1, Mux4Sel = 10, ALUOp = ADD, AluOutWrite = 1. Next ADDI_WB.
- ADDI_WB(12): regWrite = 1, regDst = 0, memtoReg = 0. Next FETCH.
- TRAP(13):
  - trap = 1; trap_cause is held in a register.
  - All other outputs are 0. Remains in TRAP until reset.
- Latencies, with mem_ready already high:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne and j: 3 cycles.
  - Each cycle mem_ready is low adds one cycle.
- opcode must be stable from DECODE until the instruction returns to FETCH; the controller does not latch it.
- Unused state encodings (14, 15) transition to RST.

Optional Feature:
- CTRL_MEM_TIMEOUT_EN defined:
  - An 8-bit-minimum wait counter, sized for TIMEOUT_CYCLES, increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready = 0.
  - The counter clears on mem_ready, on any state change, and on reset.
  - When the counter equals TIMEOUT_CYCLES with mem_ready still 0, next state is TRAP with trap_cause = 10.
- Not defined: the counter is absent, waits are unbounded, and trap_cause is only ever 00 or 01.

Test Plan:
- reset held 3 cycles, then released with mem_ready = 1 → state_out = 0 with all outputs 0 during reset; FETCH on the first cycle after release, with pcWrite = 1 and Load_ir = 1.
- opcode = 0x23, mem_ready = 1 → sequence FETCH, DECODE, ADDR, MEM_RD, LD_WB (5 cycles); LoadMDR = 1 in MEM_RD; regWrite = 1 and memtoReg = 1 in LD_WB.
- opcode = 0x04 with zero = 0, then opcode = 0x05 with zero = 0 → pcWrite = 0 in BRANCH for the first, pcWrite = 1 with pcSource = 01 for the second.
- opcode = 0x2B with mem_ready low for 4 cycles in MEM_WR → wrMem = 1 for 5 cycles, then FETCH; no regWrite at any point.
- opcode = 0x3F → DECODE then TRAP, trap = 1, trap_cause = 01, held for 10 cycles; reset pulse → RST, then FETCH.
- With CTRL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready stuck at 0 in FETCH → TRAP with trap_cause = 10 after 8 wait cycles. Without the macro → remains in FETCH indefinitely.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle datapath controller. Sequences fetch, decode, execute, memory and
// write-back steps for R-type, addi, lw, sw, beq, bne and j. Memory accesses in
// FETCH, MEM_RD and MEM_WR wait for mem_ready. An opcode it does not recognise
// halts the controller in TRAP until reset.
//
// Optional build macro: CTRL_MEM_TIMEOUT_EN
//   When defined, a wait counter bounds consecutive memory-wait cycles and
//   traps with cause 10 once it reaches TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   opcode               opcode from the instruction register (not latched)
//   zero                 ALU zero flag, used by BRANCH
//   mem_ready            memory completes the current access this cycle
//   pcWrite, pcSource    PC load enable / PC source select
//   MuxAlu1Sel, Mux4Sel  ALU operand selects
//   ALUOp                1 = ADD, 2 = SUB, 7 = decode funct
//   IMemRead, DMemRead, wrMem, Load_ir, LoadMDR   memory strobes and loads
//   regAWrite, regBWrite, AluOutWrite              datapath register loads
//   regWrite, regDst, memtoReg                     register-file write controls
//   trap, trap_cause     halt flag and cause (01 illegal opcode, 10 timeout)
//   state_out            current state, for debug
module multicycle_control #(
  parameter int OPCODE_W       = 6,
  parameter int ALUOP_W        = 3,
  parameter int STATE_W        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcWrite,
  output logic [1:0]          pcSource,
  output logic                MuxAlu1Sel,
  output logic [1:0]          Mux4Sel,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                IMemRead,
  output logic                DMemRead,
  output logic                wrMem,
  output logic                Load_ir,
  output logic                LoadMDR,
  output logic                regAWrite,
  output logic                regBWrite,
  output logic                AluOutWrite,
  output logic                regWrite,
  output logic                regDst,
  output logic                memtoReg,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [STATE_W-1:0]  state_out
);

  typedef enum logic [3:0] {
    RST     = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    R_WB    = 4'd4,
    ADDR    = 4'd5,
    MEM_RD  = 4'd6,
    LD_WB   = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ADDI_EX = 4'd11,
    ADDI_WB = 4'd12,
    TRAP    = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'd7);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state_r;
  state_t     next_s;
  logic [1:0] cause_r;
  logic [1:0] causeNext_s;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] waitCnt_r;
  logic              waitState_s;
  assign waitState_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
`endif

  // Next-state and trap-cause selection.
  always_comb begin
    next_s      = state_r;
    causeNext_s = cause_r;
    case (state_r)
      RST:     next_s = FETCH;
      FETCH:   next_s = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      next_s = EXEC_R;
          OP_LW, OP_SW:  next_s = ADDR;
          OP_BEQ, OP_BNE: next_s = BRANCH;
          OP_J:          next_s = JUMP;
          OP_ADDI:       next_s = ADDI_EX;
          default: begin
            next_s      = TRAP;
            causeNext_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC_R:  next_s = R_WB;
      R_WB:    next_s = FETCH;
      ADDR:    next_s = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  next_s = mem_ready ? LD_WB : MEM_RD;
      LD_WB:   next_s = FETCH;
      MEM_WR:  next_s = mem_ready ? FETCH : MEM_WR;
      BRANCH:  next_s = FETCH;
      JUMP:    next_s = FETCH;
      ADDI_EX: next_s = ADDI_WB;
      ADDI_WB: next_s = FETCH;
      TRAP:    next_s = TRAP;
      default: next_s = RST;  // encodings 14 and 15 recover through RST
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    if (waitState_s && !mem_ready && (waitCnt_r == WAIT_W'(TIMEOUT_CYCLES))) begin
      next_s      = TRAP;
      causeNext_s = CAUSE_TIMEOUT;
    end else begin
      causeNext_s = causeNext_s;
    end
`endif
  end

  // State, trap cause and (optionally) the memory-wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RST;
      cause_r <= CAUSE_NONE;
`ifdef CTRL_MEM_TIMEOUT_EN
      waitCnt_r <= '0;
`endif
    end else begin
      state_r <= next_s;
      cause_r <= causeNext_s;
`ifdef CTRL_MEM_TIMEOUT_EN
      // Count only uninterrupted waits within one state.
      if (mem_ready || (next_s != state_r) || !waitState_s) begin
        waitCnt_r <= '0;
      end else begin
        waitCnt_r <= waitCnt_r + WAIT_W'(1);
      end
`endif
    end
  end

  // Output decode from the current state (plus mem_ready and zero).
  always_comb begin
    pcWrite     = 1'b0;
    pcSource    = 2'b00;
    MuxAlu1Sel  = 1'b0;
    Mux4Sel     = 2'b00;
    ALUOp       = '0;
    IMemRead    = 1'b0;
    DMemRead    = 1'b0;
    wrMem       = 1'b0;
    Load_ir     = 1'b0;
    LoadMDR     = 1'b0;
    regAWrite   = 1'b0;
    regBWrite   = 1'b0;
    AluOutWrite = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memtoReg    = 1'b0;
    trap        = 1'b0;
    trap_cause  = CAUSE_NONE;
    case (state_r)
      FETCH: begin
        IMemRead = 1'b1;
        Mux4Sel  = 2'b01;
        ALUOp    = ALU_ADD;
        Load_ir  = mem_ready;
        pcWrite  = mem_ready;
      end
      DECODE: begin
        regAWrite   = 1'b1;
        regBWrite   = 1'b1;
        Mux4Sel     = 2'b11;
        ALUOp       = ALU_ADD;
        AluOutWrite = 1'b1;
      end
      EXEC_R: begin
        MuxAlu1Sel  = 1'b1;
        ALUOp       = ALU_FUNCT;
        AluOutWrite = 1'b1;
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      ADDR, ADDI_EX: begin
        MuxAlu1Sel  = 1'b1;
        Mux4Sel     = 2'b10;
        ALUOp       = ALU_ADD;
        AluOutWrite = 1'b1;
      end
      MEM_RD: begin
        DMemRead = 1'b1;
        LoadMDR  = mem_ready;
      end
      LD_WB: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
      end
      MEM_WR:  wrMem = 1'b1;
      BRANCH: begin
        MuxAlu1Sel = 1'b1;
        ALUOp      = ALU_SUB;
        pcSource   = 2'b01;
        if (opcode == OP_BEQ) begin
          pcWrite = zero;
        end else if (opcode == OP_BNE) begin
          pcWrite = !zero;
        end else begin
          pcWrite = 1'b0;
        end
      end
      JUMP: begin
        pcSource = 2'b10;
        pcWrite  = 1'b1;
      end
      ADDI_WB: regWrite = 1'b1;
      TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_r;
      end
      default: trap = 1'b0;
    endcase
  end

  assign state_out = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: scoreboard of expected output vectors,
// pushed as each cycle's stimulus is driven and popped at the falling edge.
module tb_multicycle_control;

  localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_R_WB = 4'd4, S_ADDR = 4'd5, S_MEM_RD = 4'd6, S_LD_WB = 4'd7,
                         S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10,
                         S_ADDI_EX = 4'd11, S_ADDI_WB = 4'd12, S_TRAP = 4'd13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcWrite, MuxAlu1Sel, IMemRead, DMemRead, wrMem, Load_ir, LoadMDR;
  logic       regAWrite, regBWrite, AluOutWrite, regWrite, regDst, memtoReg, trap;
  logic [1:0] pcSource, Mux4Sel, trap_cause;
  logic [2:0] ALUOp;
  logic [3:0] state_out;

  int numChecks = 0;
  int numErrors = 0;
  logic [27:0] sbQ[$];
  logic [27:0] dutVec;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcSource(pcSource), .MuxAlu1Sel(MuxAlu1Sel), .Mux4Sel(Mux4Sel),
    .ALUOp(ALUOp), .IMemRead(IMemRead), .DMemRead(DMemRead), .wrMem(wrMem),
    .Load_ir(Load_ir), .LoadMDR(LoadMDR), .regAWrite(regAWrite), .regBWrite(regBWrite),
    .AluOutWrite(AluOutWrite), .regWrite(regWrite), .regDst(regDst), .memtoReg(memtoReg),
    .trap(trap), .trap_cause(trap_cause), .state_out(state_out)
  );

  always #5 clk = ~clk;

  assign dutVec = {pcWrite, pcSource, MuxAlu1Sel, Mux4Sel, ALUOp, IMemRead, DMemRead, wrMem,
                   Load_ir, LoadMDR, regAWrite, regBWrite, AluOutWrite, regWrite, regDst,
                   memtoReg, trap, trap_cause, state_out};

  // Expected output vector for a state, written out from the state table.
  function automatic logic [27:0] expVec(input logic [3:0] st, input logic [5:0] op,
                                         input logic mr, input logic z);
    logic pw, a1, imr, dmr, wm, lir, lmdr, raw, rbw, aow, rw, rd, mtr, tr;
    logic [1:0] ps, m4, tc;
    logic [2:0] aop;
    {pw, a1, imr, dmr, wm, lir, lmdr, raw, rbw, aow, rw, rd, mtr, tr} = 14'b0;
    ps = 2'b00; m4 = 2'b00; tc = 2'b00; aop = 3'd0;
    case (st)
      S_FETCH:   begin imr = 1'b1; m4 = 2'b01; aop = 3'd1; pw = mr; lir = mr; end
      S_DECODE:  begin raw = 1'b1; rbw = 1'b1; m4 = 2'b11; aop = 3'd1; aow = 1'b1; end
      S_EXEC_R:  begin a1 = 1'b1; aop = 3'd7; aow = 1'b1; end
      S_R_WB:    begin rw = 1'b1; rd = 1'b1; end
      S_ADDR:    begin a1 = 1'b1; m4 = 2'b10; aop = 3'd1; aow = 1'b1; end
      S_MEM_RD:  begin dmr = 1'b1; lmdr = mr; end
      S_LD_WB:   begin rw = 1'b1; mtr = 1'b1; end
      S_MEM_WR:  wm = 1'b1;
      S_BRANCH:  begin
        a1 = 1'b1; aop = 3'd2; ps = 2'b01;
        pw = (op == 6'h04) ? z : ((op == 6'h05) ? !z : 1'b0);
      end
      S_JUMP:    begin ps = 2'b10; pw = 1'b1; end
      S_ADDI_EX: begin a1 = 1'b1; m4 = 2'b10; aop = 3'd1; aow = 1'b1; end
      S_ADDI_WB: rw = 1'b1;
      S_TRAP:    begin tr = 1'b1; tc = 2'b01; end
      default:   tr = 1'b0;
    endcase
    return {pw, ps, a1, m4, aop, imr, dmr, wm, lir, lmdr, raw, rbw, aow, rw, rd, mtr, tr, tc, st};
  endfunction

  task automatic checkVal(input string tag, input logic [27:0] got, input logic [27:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               tag, got, got[3:0], exp, exp[3:0]);
    end
  endtask

  // One clock: drive inputs after the rising edge, queue the expectation,
  // then compare at the falling edge.
  task automatic cycle(input string tag, input logic rst, input logic [5:0] op,
                       input logic mr, input logic z, input logic [3:0] st);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; mem_ready = mr; zero = z;
    sbQ.push_back(expVec(st, op, mr, z));
    @(negedge clk);
    checkVal(tag, dutVec, sbQ.pop_front());
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic mr,
                     input logic z, input logic [3:0] st);
    cycle(tag, 1'b0, op, mr, z, st);
  endtask

  initial begin
    // Reset held for three edges, then released with mem_ready high.
    cycle("rst1", 1'b1, 6'h23, 1'b1, 1'b0, S_RST);
    cycle("rst2", 1'b1, 6'h23, 1'b1, 1'b0, S_RST);
    cycle("rst3", 1'b0, 6'h23, 1'b1, 1'b0, S_RST);
    // lw, no waits: 5 cycles.
    run("lw_fetch",  6'h23, 1'b1, 1'b0, S_FETCH);
    run("lw_dec",    6'h23, 1'b1, 1'b0, S_DECODE);
    run("lw_addr",   6'h23, 1'b1, 1'b0, S_ADDR);
    run("lw_memrd",  6'h23, 1'b1, 1'b0, S_MEM_RD);
    run("lw_wb",     6'h23, 1'b1, 1'b0, S_LD_WB);
    // beq zero=0 (not taken), bne zero=0 (taken), beq zero=1 (taken).
    run("beq_fetch", 6'h04, 1'b1, 1'b0, S_FETCH);
    run("beq_dec",   6'h04, 1'b1, 1'b0, S_DECODE);
    run("beq_br",    6'h04, 1'b1, 1'b0, S_BRANCH);
    run("bne_fetch", 6'h05, 1'b1, 1'b0, S_FETCH);
    run("bne_dec",   6'h05, 1'b1, 1'b0, S_DECODE);
    run("bne_br",    6'h05, 1'b1, 1'b0, S_BRANCH);
    run("beqz_fetch", 6'h04, 1'b1, 1'b1, S_FETCH);
    run("beqz_dec",  6'h04, 1'b1, 1'b1, S_DECODE);
    run("beqz_br",   6'h04, 1'b1, 1'b1, S_BRANCH);
    // R-type, addi, j.
    run("r_fetch",   6'h00, 1'b1, 1'b0, S_FETCH);
    run("r_dec",     6'h00, 1'b1, 1'b0, S_DECODE);
    run("r_exec",    6'h00, 1'b1, 1'b0, S_EXEC_R);
    run("r_wb",      6'h00, 1'b1, 1'b0, S_R_WB);
    run("addi_fetch", 6'h08, 1'b1, 1'b0, S_FETCH);
    run("addi_dec",  6'h08, 1'b1, 1'b0, S_DECODE);
    run("addi_ex",   6'h08, 1'b1, 1'b0, S_ADDI_EX);
    run("addi_wb",   6'h08, 1'b1, 1'b0, S_ADDI_WB);
    run("j_fetch",   6'h02, 1'b1, 1'b0, S_FETCH);
    run("j_dec",     6'h02, 1'b1, 1'b0, S_DECODE);
    run("j_jump",    6'h02, 1'b1, 1'b0, S_JUMP);
    // sw with four wait cycles in MEM_WR (wrMem high for five cycles).
    run("sw_fetch",  6'h2B, 1'b1, 1'b0, S_FETCH);
    run("sw_dec",    6'h2B, 1'b1, 1'b0, S_DECODE);
    run("sw_addr",   6'h2B, 1'b1, 1'b0, S_ADDR);
    for (int i = 0; i < 4; i++) run("sw_wait", 6'h2B, 1'b0, 1'b0, S_MEM_WR);
    run("sw_done",   6'h2B, 1'b1, 1'b0, S_MEM_WR);
    // Fetch wait, then lw with two MEM_RD waits.
    run("lww_fw",    6'h23, 1'b0, 1'b0, S_FETCH);
    run("lww_fetch", 6'h23, 1'b1, 1'b0, S_FETCH);
    run("lww_dec",   6'h23, 1'b1, 1'b0, S_DECODE);
    run("lww_addr",  6'h23, 1'b1, 1'b0, S_ADDR);
    run("lww_rw1",   6'h23, 1'b0, 1'b0, S_MEM_RD);
    run("lww_rw2",   6'h23, 1'b0, 1'b0, S_MEM_RD);
    run("lww_rd",    6'h23, 1'b1, 1'b0, S_MEM_RD);
    run("lww_wb",    6'h23, 1'b1, 1'b0, S_LD_WB);
    // Reset in the middle of a MEM_WR wait.
    run("swr_fetch", 6'h2B, 1'b1, 1'b0, S_FETCH);
    run("swr_dec",   6'h2B, 1'b1, 1'b0, S_DECODE);
    run("swr_addr",  6'h2B, 1'b1, 1'b0, S_ADDR);
    run("swr_wait",  6'h2B, 1'b0, 1'b0, S_MEM_WR);
    cycle("swr_rstin", 1'b1, 6'h2B, 1'b0, 1'b0, S_MEM_WR);
    run("swr_rst",   6'h2B, 1'b1, 1'b0, S_RST);
    // Illegal opcode: trap held for ten cycles, then reset.
    run("ill_fetch", 6'h3F, 1'b1, 1'b0, S_FETCH);
    run("ill_dec",   6'h3F, 1'b1, 1'b0, S_DECODE);
    for (int i = 0; i < 10; i++) run("ill_trap", 6'h3F, 1'($urandom_range(1)), 1'b0, S_TRAP);
    cycle("ill_rstin", 1'b1, 6'h3F, 1'b1, 1'b0, S_TRAP);
    run("ill_rst",   6'h00, 1'b1, 1'b0, S_RST);
    // Unbounded fetch wait in the default build.
    for (int i = 0; i < 20; i++) run("fetch_stall", 6'h02, 1'b0, 1'b0, S_FETCH);
    run("stall_end", 6'h02, 1'b1, 1'b0, S_FETCH);
    run("stall_dec", 6'h02, 1'b1, 1'b0, S_DECODE);
    run("stall_j",   6'h02, 1'b1, 1'b0, S_JUMP);
    run("stall_nxt", 6'h02, 1'b1, 1'b0, S_FETCH);
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
